strobe_sched: RTL and testbench
===============================

# strobe_sched

Multi-channel, parametrised sync-strobe scheduler for the sample-rate domain. A master modulo counter of programmable period drives `NCHAN` independent one-cycle strobes, each with its own programmable phase offset. Period and phase updates are double-buffered and applied only at period boundaries, so downstream decimators and interpolators never see a runt period. Continuous and single-shot modes are supported. It sits between the register bank and the CIC/halfband enable inputs.

## Interface
- `WIDTH`, default 8: counter, rate and phase width in bits.
- `NCHAN`, default 4: number of strobe channels.
- `clock` in 1: sample clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: run permission; low forces IDLE.
- `oneshot` in 1: 1 selects single-shot mode, 0 selects continuous mode.
- `start` in 1: single-shot trigger pulse; ignored when `oneshot`=0.
- `rate` in WIDTH: period minus 1 (period = `rate`+1 cycles).
- `rate_load` in 1: captures `rate` into the pending register.
- `phase` in NCHAN*WIDTH: per-channel offset; channel i occupies `[i*WIDTH +: WIDTH]`.
- `phase_load` in 1: captures all of `phase` into the pending registers.
- `strobe` out NCHAN: per-channel one-cycle strobes.
- `wrap` out 1: one-cycle pulse on the last count of each period.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse when a single-shot period completes.

## Operation
- Registers:
  - `cnt`, WIDTH bits.
  - `rate_pend` and `rate_act`.
  - `phase_pend[i]` and `phase_act[i]`.
  - state ∈ {IDLE, RUN}.
- Reset: `cnt`=0, state=IDLE, all pend/act registers=0, all outputs 0.
- IDLE:
  - `cnt` is held at 0.
  - `rate_act`/`phase_act` copy their pending values every cycle.
  - Go to RUN when `enable` && (!`oneshot` || `start`).
- RUN:
  - `cnt` increments by 1 each cycle.
  - When `cnt`==`rate_act`, `cnt` goes to 0. This is the terminal count (tc).
  - At tc, `rate_act`/`phase_act` load their pending values.
- RUN → IDLE when `enable`=0 (any cycle, mid-period abort) or when `oneshot` && tc.
  - A mode change while in RUN takes effect at the next tc check.
- Load bypass: if `rate_load`/`phase_load` coincide with tc, or occur in IDLE, the act register takes the incoming port value directly. The new value takes effect on the very next period.
- Comparisons are unsigned, WIDTH bits. No arithmetic overflow is possible because `cnt` ≤ `rate_act`.
- Edge cases:
  - If `phase_act[i]` > `rate_act`, channel i never fires.
  - `rate`=0: tc occurs every cycle, so `wrap` is constantly high in RUN and a phase-0 channel fires every cycle.
- `start` while in RUN is ignored. A single-shot run can only be re-armed from IDLE.

## Timing
- All outputs are registered and reflect the counter state of the previous cycle.
- `strobe[i]` is high in cycle n+1 iff the state was RUN in cycle n and `cnt`==`phase_act[i]`.
- `wrap` is high in cycle n+1 iff tc occurred in cycle n.
- `done` is high in cycle n+1 iff the single-shot exit occurred in cycle n. It coincides with the final `wrap`.
- `busy` is the registered state. It goes high one cycle after the IDLE→RUN decision and low one cycle after exit.
- Latency from `start` to the first phase-0 strobe is 2 cycles: cycle 0 `start`, cycle 1 RUN with `cnt`=0, cycle 2 `strobe`.
- Abort via `enable`=0: no strobe, `wrap` or `done` is issued for the aborted cycle. Outputs are 0 from the next cycle on.
- Reset mid-run: all outputs are 0 in the cycle after reset is sampled.

## Structure
- Package `strobe_sched_pkg`: state enum (IDLE, RUN) and a `WIDTH`-parametrised helper for slicing the phase vector.
- Sub-module `strobe_chan`, instantiated NCHAN times via generate. It holds the pending/act phase registers, the comparator and the output strobe register. Inputs: `cnt`, `run`, `tc`, load and bypass controls.
- The top level holds the counter, the rate shadow registers and the FSM.

## Test plan
- Continuous, `rate`=4, phases {0,2,4,7}: `wrap` every 5 cycles; ch0/1/2 fire 1, 3 and 5 cycles after each `cnt`=0; ch3 never fires.
- `rate_load` of 9 mid-period with `rate_act`=4: the current period still lasts 5 cycles, the next lasts 10. Repeat with `rate_load` on the tc cycle: the new period takes effect immediately.
- Single-shot, `rate`=3, `start` in cycle 0: `busy` high in cycles 2–5; `wrap` and `done` high in cycle 5; returns to IDLE. A second `start` while `busy` is ignored.
- `rate`=0, phase 0 continuous: `wrap` and `strobe[0]` high every cycle while `busy`.
- `enable` dropped at `cnt`=2 of a period with `rate`=6: no further strobes or `wrap`; `cnt` is 0 and `busy` is 0 from the next cycle.
- `reset` asserted mid-run with `WIDTH`=16, `NCHAN`=8: all outputs 0 next cycle; pending/act registers read back 0 after restart (`wrap` every cycle until reloaded).

Source files
------------

// File: rtl/strobe_sched_pkg.sv
// Shared types and helpers for the strobe scheduler: FSM state encoding and
// the bit offset of a channel inside the packed phase vector.
package strobe_sched_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Channel chan occupies phase[chan*width +: width].
   function automatic int phase_lsb(input int chan, input int width);
      return chan * width;
   endfunction

endpackage

// File: rtl/strobe_sched_if.sv
// Control/strobe bundle between the register bank (master) and the scheduler (slave).
interface strobe_sched_if #(
   parameter int WIDTH = 8,
   parameter int NCHAN = 4
) ();
   logic                   enable;
   logic                   oneshot;
   logic                   start;
   logic [WIDTH-1:0]       rate;
   logic                   rate_load;
   logic [NCHAN*WIDTH-1:0] phase;
   logic                   phase_load;
   logic [NCHAN-1:0]       strobe;
   logic                   wrap;
   logic                   busy;
   logic                   done;

   modport master (
      output enable, oneshot, start, rate, rate_load, phase, phase_load,
      input  strobe, wrap, busy, done
   );

   modport slave (
      input  enable, oneshot, start, rate, rate_load, phase, phase_load,
      output strobe, wrap, busy, done
   );
endinterface

// File: rtl/strobe_sched_chan.sv
// One strobe channel: double-buffered phase offset, comparator against the
// master count, and the registered one-cycle strobe.
module strobe_chan #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] cnt,
   input  logic             run,
   input  logic             tc,
   input  logic             idle,
   input  logic [WIDTH-1:0] phase_in,
   input  logic             phase_load,
   output logic             strobe
);
   logic [WIDTH-1:0] phase_pend;
   logic [WIDTH-1:0] phase_act;
   logic             apply;

   assign apply = idle || tc;

   // A load coinciding with the apply point bypasses the pending register.
   always_ff @(posedge clock) begin
      if (reset) begin
         phase_pend <= '0;
         phase_act  <= '0;
         strobe     <= 1'b0;
      end else begin
         if (phase_load)
            phase_pend <= phase_in;
         if (apply)
            phase_act <= phase_load ? phase_in : phase_pend;
         strobe <= run && (cnt == phase_act);
      end
   end
endmodule

// File: rtl/strobe_sched.sv
// Multi-channel strobe scheduler: modulo counter with double-buffered period,
// IDLE/RUN control FSM, and NCHAN phase-offset strobe channels.
module strobe_sched
   import strobe_sched_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NCHAN = 4
) (
   input  logic           clock,
   input  logic           reset,
   strobe_sched_if.slave  bus
);
   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] rate_pend;
   logic [WIDTH-1:0] rate_act;
   logic             run;
   logic             tc;
   logic             idle;
   logic [NCHAN-1:0] strobe_q;
   logic             wrap_q;
   logic             busy_q;
   logic             done_q;

   always_ff @(posedge clock) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.enable && (!bus.oneshot || bus.start)) state_next = RUN;
         RUN:     if (!bus.enable || (bus.oneshot && tc))        state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Dropping enable masks the current cycle entirely, so run already excludes it.
   always_comb begin
      idle = (state == IDLE);
      run  = (state == RUN) && bus.enable;
      tc   = run && (cnt == rate_act);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt       <= '0;
         rate_pend <= '0;
         rate_act  <= '0;
         wrap_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         cnt <= (run && !tc) ? cnt + 1'b1 : '0;
         if (bus.rate_load)
            rate_pend <= bus.rate;
         if (idle || tc)
            rate_act <= bus.rate_load ? bus.rate : rate_pend;
         wrap_q <= tc;
         done_q <= tc && bus.oneshot;
         busy_q <= run;
      end
   end

   for (genvar i = 0; i < NCHAN; i++) begin : g_chan
      strobe_chan #(.WIDTH(WIDTH)) u_chan (
         .clock      (clock),
         .reset      (reset),
         .cnt        (cnt),
         .run        (run),
         .tc         (tc),
         .idle       (idle),
         .phase_in   (bus.phase[phase_lsb(i, WIDTH) +: WIDTH]),
         .phase_load (bus.phase_load),
         .strobe     (strobe_q[i])
      );
   end

   assign bus.strobe = strobe_q;
   assign bus.wrap   = wrap_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
endmodule

// File: tb/tb_strobe_sched.sv
// Directed bench for strobe_sched (WIDTH=16, NCHAN=8): continuous, rate reload,
// single-shot, rate=0, abort and mid-run reset scenarios.
module tb_strobe_sched;
   localparam int W = 16;
   localparam int N = 8;

   logic clock = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;

   strobe_sched_if #(.WIDTH(W), .NCHAN(N)) bus ();

   strobe_sched #(.WIDTH(W), .NCHAN(N)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic b, input logic d,
                      input logic w, input logic [N-1:0] s);
      logic [N+2:0] obs;
      logic [N+2:0] exp;
      obs = {bus.busy, bus.done, bus.wrap, bus.strobe};
      exp = {b, d, w, s};
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed busy/done/wrap/strobe=%h expected %h", tag, obs, exp);
      end
   endtask

   // Strobe pattern for phases {0,2,4,7} (ch4..7 parked out of range) at count m.
   function automatic logic [N-1:0] dec(input int m);
      logic [N-1:0] s;
      s    = '0;
      s[0] = (m == 0);
      s[1] = (m == 2);
      s[2] = (m == 4);
      s[3] = (m == 7);
      return s;
   endfunction

   task automatic chk_idle(input string tag);
      chk(tag, 1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic chk_run(input string tag, input int m, input logic w, input logic d);
      chk($sformatf("%s_m%0d", tag, m), 1'b1, d, w, dec(m));
   endtask

   initial begin
      reset          = 1'b1;
      bus.enable     = 1'b0;
      bus.oneshot    = 1'b0;
      bus.start      = 1'b0;
      bus.rate       = '0;
      bus.rate_load  = 1'b0;
      bus.phase      = '0;
      bus.phase_load = 1'b0;
      tick();
      tick();
      chk_idle("reset");
      reset = 1'b0;
      tick();
      chk_idle("post_reset");

      // Continuous, rate=4, phases {0,2,4,7}
      bus.rate       = 16'd4;
      bus.rate_load  = 1'b1;
      bus.phase      = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                        16'd7, 16'd4, 16'd2, 16'd0};
      bus.phase_load = 1'b1;
      bus.enable     = 1'b1;
      tick();
      bus.rate_load  = 1'b0;
      bus.phase_load = 1'b0;
      chk_idle("cont_first");
      for (int k = 0; k < 11; k++) begin
         tick();
         chk_run("cont", k % 5, (k % 5) == 4, 1'b0);
      end

      // rate_load of 9 mid-period: current period finishes at 5 cycles
      bus.rate      = 16'd9;
      bus.rate_load = 1'b1;
      tick();
      bus.rate_load = 1'b0;
      chk_run("midload", 1, 1'b0, 1'b0);
      for (int m = 2; m <= 4; m++) begin
         tick();
         chk_run("midload", m, m == 4, 1'b0);
      end
      for (int m = 0; m <= 9; m++) begin
         tick();
         chk_run("rate9", m, m == 9, 1'b0);
      end
      for (int m = 0; m <= 8; m++) begin
         tick();
         chk_run("rate9b", m, 1'b0, 1'b0);
      end

      // rate_load of 4 on the tc cycle takes effect at once
      bus.rate      = 16'd4;
      bus.rate_load = 1'b1;
      tick();
      bus.rate_load = 1'b0;
      chk_run("tcload", 9, 1'b1, 1'b0);
      for (int m = 0; m <= 4; m++) begin
         tick();
         chk_run("tcload", m, m == 4, 1'b0);
      end
      bus.enable = 1'b0;
      tick();
      chk_idle("stop");

      // Single-shot, rate=3, start at cycle 0; second start while busy ignored
      bus.rate      = 16'd3;
      bus.rate_load = 1'b1;
      bus.oneshot   = 1'b1;
      bus.enable    = 1'b1;
      bus.start     = 1'b1;
      tick();
      bus.rate_load = 1'b0;
      bus.start     = 1'b0;
      chk_idle("ss_c1");
      bus.start = 1'b1;
      tick();
      chk_run("ss_c2", 0, 1'b0, 1'b0);
      tick();
      chk_run("ss_c3", 1, 1'b0, 1'b0);
      bus.start = 1'b0;
      tick();
      chk_run("ss_c4", 2, 1'b0, 1'b0);
      tick();
      chk_run("ss_c5", 3, 1'b1, 1'b1);
      tick();
      chk_idle("ss_c6");
      tick();
      chk_idle("ss_c7");

      // rate=0 continuous: wrap and ch0 every cycle
      bus.oneshot   = 1'b0;
      bus.rate      = 16'd0;
      bus.rate_load = 1'b1;
      tick();
      bus.rate_load = 1'b0;
      chk_idle("r0_first");
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_run("r0", 0, 1'b1, 1'b0);
      end
      bus.enable = 1'b0;
      tick();
      chk_idle("r0_stop");

      // Abort at cnt=2 with rate=6
      bus.rate      = 16'd6;
      bus.rate_load = 1'b1;
      bus.enable    = 1'b1;
      tick();
      bus.rate_load = 1'b0;
      chk_idle("ab_first");
      tick();
      chk_run("ab", 0, 1'b0, 1'b0);
      tick();
      chk_run("ab", 1, 1'b0, 1'b0);
      bus.enable = 1'b0;
      tick();
      chk_idle("ab_next");
      tick();
      chk_idle("ab_idle");
      bus.enable = 1'b1;
      tick();
      chk_idle("ab_rearm");
      for (int m = 0; m <= 2; m++) begin
         tick();
         chk_run("ab_restart", m, 1'b0, 1'b0);
      end

      // Reset mid-run: outputs clear, shadow registers read back as zero
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_idle("rst_mid");
      tick();
      chk_idle("rst_restart");
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("rst_zero%0d", k), 1'b1, 1'b0, 1'b1, {N{1'b1}});
      end
      bus.enable = 1'b0;
      tick();
      chk_idle("end_idle");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
